peaton_boton_req: RTL and testbench

- Pedestrian push-button front end for the traffic-light controller, sitting directly upstream of it.
- Synchronises and debounces the raw button input.
- Converts each valid press into a level request `req`, held until the light controller acknowledges it with `ack` when it enters the green-for-pedestrian phase.
- After each acknowledgement, a lockout window discards further presses so one crossing cycle is not re-requested immediately.

---
 rtl/peaton_boton_req.sv | 132 +++++++++++++
 tb/tb_peaton_boton_req.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/peaton_boton_req.sv
`default_nettype none
// ============================================================================
// peaton_boton_req : pedestrian button synchroniser, debouncer and
//                    request/lockout handshake toward the light controller.
//                    Macro PEATON_CONTADOR_EN adds 8-bit saturating press_cnt.
// Revision 1.0
// ============================================================================
module peaton_boton_req #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       ack,
  output logic       req,
  output logic       busy,
  output logic       btn_db
`ifdef PEATON_CONTADOR_EN
  ,
  output logic [7:0] press_cnt
`endif
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_LK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
  localparam logic [c_LK_W-1:0] c_LK_LOAD = c_LK_W'(LOCKOUT_CYCLES);
  localparam logic [c_LK_W-1:0] c_LK_ONE  = c_LK_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_db_d;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic [c_LK_W-1:0]  r_lk_cnt;
  logic               w_press_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db   <= 1'b0;
      r_db_d   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_db_d <= btn_db;
      if (r_sync2 == btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        btn_db   <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_ONE;
      end
    end
  end

  assign w_press_evt = btn_db & ~r_db_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      req      <= 1'b0;
      busy     <= 1'b0;
      r_lk_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press_evt) begin
            r_state <= PEND;
            req     <= 1'b1;
          end
        end
        PEND: begin
          // ack has priority; a coincident press is dropped since requests do not queue.
          if (ack) begin
            req <= 1'b0;
            if (LOCKOUT_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_state  <= LOCK;
              busy     <= 1'b1;
              r_lk_cnt <= c_LK_LOAD;
            end
          end
        end
        LOCK: begin
          if (r_lk_cnt == c_LK_ONE) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_lk_cnt <= r_lk_cnt - c_LK_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          req     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PEATON_CONTADOR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt <= 8'd0;
    end else if ((r_state == IDLE) && w_press_evt && (press_cnt != 8'hFF)) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_peaton_boton_req.sv
`default_nettype none
// ============================================================================
// tb_peaton_boton_req : directed + randomized bench with a cycle-level
//                       behavioural model of the pedestrian request front end.
// Revision 1.0
// ============================================================================
module tb_peaton_boton_req;

  localparam int DEB = 4;
  localparam int LCK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic ack = 1'b0;
  logic req;
  logic busy;
  logic btn_db;
`ifdef PEATON_CONTADOR_EN
  logic [7:0] press_cnt;
`endif

  always #5 clk = ~clk;

  peaton_boton_req #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LCK)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .ack   (ack),
    .req   (req),
    .busy  (busy),
    .btn_db(btn_db)
`ifdef PEATON_CONTADOR_EN
    ,
    .press_cnt(press_cnt)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: delayed samples of btn, run length of disagreement,
  // pending flag and remaining lockout cycles.
  bit m_d1, m_d2, m_db, m_rose, m_pend;
  int m_run, m_lock_left, m_cnt;

  task automatic model_edge();
    bit evt;
    if (rst) begin
      m_d1 = 0; m_d2 = 0; m_db = 0; m_rose = 0; m_pend = 0;
      m_run = 0; m_lock_left = 0; m_cnt = 0;
    end else begin
      evt    = m_rose;
      m_rose = 0;
      if (m_d2 != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db   = m_d2;
          m_run  = 0;
          m_rose = m_db;
        end
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = btn;
      if (m_lock_left > 0) begin
        m_lock_left--;
      end else if (m_pend) begin
        if (ack) begin
          m_pend      = 0;
          m_lock_left = LCK;
        end
      end else if (evt) begin
        m_pend = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input bit r, input bit b, input bit a);
    rst = r;
    btn = b;
    ack = a;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_req", {7'd0, req}, {7'd0, m_pend});
    chk("model_busy", {7'd0, busy}, {7'd0, (m_lock_left > 0)});
    chk("model_btn_db", {7'd0, btn_db}, {7'd0, m_db});
`ifdef PEATON_CONTADOR_EN
    chk("model_press_cnt", press_cnt, m_cnt[7:0]);
`endif
  endtask

  initial begin
    bit rb;
    int rlen;

    // Reset state
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_req", {7'd0, req}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_btn_db", {7'd0, btn_db}, 8'd0);

    // Short glitches never reach the debounced level
    for (int g = 0; g < 5; g++) begin
      for (int j = 0; j < 3; j++) step(0, 1, 0);
      for (int j = 0; j < 3; j++) step(0, 0, 0);
    end
    chk("glitch_btn_db", {7'd0, btn_db}, 8'd0);
    chk("glitch_req", {7'd0, req}, 8'd0);
`ifdef PEATON_CONTADOR_EN
    chk("glitch_press_cnt", press_cnt, 8'd0);
`endif

    // Press latency from reset
    step(1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step(0, 1, 0);
      chk("lat_req", {7'd0, req}, (i >= 7) ? 8'd1 : 8'd0);
      chk("lat_btn_db", {7'd0, btn_db}, (i >= 6) ? 8'd1 : 8'd0);
      chk("lat_busy", {7'd0, busy}, 8'd0);
    end

    // Ack with button still held: exactly LCK busy cycles, no re-request
    step(0, 1, 1);
    chk("ack_req", {7'd0, req}, 8'd0);
    chk("ack_busy", {7'd0, busy}, 8'd1);
    for (int i = 1; i < LCK; i++) begin
      step(0, 1, 0);
      chk("lock_busy", {7'd0, busy}, 8'd1);
    end
    step(0, 1, 0);
    chk("lock_end_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      chk("held_no_req", {7'd0, req}, 8'd0);
    end

    // Press during lockout is discarded; a later press is accepted
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    chk("pend_again", {7'd0, req}, 8'd1);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      chk("lockpress_req", {7'd0, req}, 8'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      chk("lockpress_after", {7'd0, req}, 8'd0);
    end
    chk("lockpress_busy", {7'd0, busy}, 8'd0);
    for (int i = 1; i <= 7; i++) begin
      step(0, 1, 0);
      chk("repress_req", {7'd0, req}, (i >= 7) ? 8'd1 : 8'd0);
    end

    // Reset mid-request, then the held button re-requests
    step(1, 1, 0);
    chk("rstpend_req", {7'd0, req}, 8'd0);
    chk("rstpend_busy", {7'd0, busy}, 8'd0);
    chk("rstpend_btn_db", {7'd0, btn_db}, 8'd0);
    for (int i = 1; i <= 7; i++) begin
      step(0, 1, 0);
      chk("rstpend_again", {7'd0, req}, (i >= 7) ? 8'd1 : 8'd0);
    end

    // Randomized segments checked against the model every cycle
    for (int seg = 0; seg < 400; seg++) begin
      rb   = 1'($urandom_range(0, 1));
      rlen = int'($urandom_range(1, 10));
      for (int j = 0; j < rlen; j++)
        step(($urandom_range(0, 299) == 0), rb, ($urandom_range(0, 3) == 0));
    end

`ifdef PEATON_CONTADOR_EN
    // Saturation of the accepted-request counter
    step(1, 0, 0);
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < 7; i++) step(0, 1, 0);
      step(0, 1, 1);
      for (int i = 0; i < 9; i++) step(0, 0, 0);
      if (k == 254) chk("cnt_255", press_cnt, 8'd255);
    end
    chk("cnt_sat", press_cnt, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
